// File: rtl/keymap_pkg.sv
// Shared types and keycode constants for keymap_arbiter and its per-player slices.
// Optional build macro KEYMAP_DEBOUNCE_EN is consumed by keymap_player.
package keymap_pkg;

    typedef enum logic [1:0] {
        H_IDLE  = 2'd0,
        H_LEFT  = 2'd1,
        H_RIGHT = 2'd2
    } h_state_t;

    typedef struct packed {
        logic l;
        logic r;
        logic u;
    } dir_t;

    localparam logic [7:0] KEY_NONE     = 8'h00;
    localparam logic [7:0] KEY_ROLLOVER = 8'h01;

    // A disabled binding (00) never matches, so an empty slot can never press it.
    function automatic logic key_hit(input logic [7:0] slot, input logic [7:0] bind_code);
        return (bind_code != KEY_NONE) && (slot == bind_code);
    endfunction

endpackage

// File: rtl/keymap_player.sv
// One player's key decode, optional debounce, last-pressed-wins horizontal FSM and jump edge.
// Build macro KEYMAP_DEBOUNCE_EN adds per-bit stable-sample counters ahead of the held register.
module keymap_player
    import keymap_pkg::*;
#(
    parameter int         NUM_SLOTS       = 4,
    parameter logic [7:0] BIND_L          = 8'h04,
    parameter logic [7:0] BIND_R          = 8'h07,
    parameter logic [7:0] BIND_U          = 8'h1a,
    parameter int         DEBOUNCE_CYCLES = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [NUM_SLOTS*8-1:0] keys_in,
    input  logic                   reject,
    output logic [15:0]            keycode,
    output logic                   jump_pulse
);

    dir_t     raw_p0;
    dir_t     held_p1;
    dir_t     prev_p1;
    h_state_t state_p2;
    h_state_t state_nxt;
    logic     up_p2;
    logic     jump_p2;
    logic     press_l;
    logic     press_r;
    logic [7:0] horiz;

    // Stage 0: raw decode of the current slots; duplicates collapse into one bit.
    always_comb begin
        raw_p0 = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (key_hit(keys_in[8*s +: 8], BIND_L)) raw_p0.l = 1'b1;
            if (key_hit(keys_in[8*s +: 8], BIND_R)) raw_p0.r = 1'b1;
            if (key_hit(keys_in[8*s +: 8], BIND_U)) raw_p0.u = 1'b1;
        end
    end

    // Stage 1: held/previous-held registers; prev follows held even on rejected samples.
`ifdef KEYMAP_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] cnt_p1 [3];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            held_p1 <= '0;
            prev_p1 <= '0;
            for (int i = 0; i < 3; i++) cnt_p1[i] <= '0;
        end else begin
            prev_p1 <= held_p1;
            if (!reject) begin
                for (int i = 0; i < 3; i++) begin
                    if (raw_p0[i] == held_p1[i]) begin
                        cnt_p1[i] <= '0;
                    end else if (cnt_p1[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                        held_p1[i] <= raw_p0[i];
                        cnt_p1[i]  <= '0;
                    end else begin
                        cnt_p1[i] <= cnt_p1[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            held_p1 <= '0;
            prev_p1 <= '0;
        end else begin
            prev_p1 <= held_p1;
            if (!reject) held_p1 <= raw_p0;
        end
    end
`endif

    assign press_l = held_p1.l & ~prev_p1.l;
    assign press_r = held_p1.r & ~prev_p1.r;

    // Stage 2: horizontal FSM state, up level and jump edge.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_p2 <= H_IDLE;
            up_p2    <= 1'b0;
            jump_p2  <= 1'b0;
        end else begin
            state_p2 <= state_nxt;
            up_p2    <= held_p1.u;
            jump_p2  <= held_p1.u & ~prev_p1.u;
        end
    end

    always_comb begin
        state_nxt = state_p2;
        if (press_l && press_r) begin
            state_nxt = H_IDLE;
        end else if (press_l) begin
            state_nxt = H_LEFT;
        end else if (press_r) begin
            state_nxt = H_RIGHT;
        end else begin
            case (state_p2)
                H_LEFT:  if (!held_p1.l) state_nxt = held_p1.r ? H_RIGHT : H_IDLE;
                H_RIGHT: if (!held_p1.r) state_nxt = held_p1.l ? H_LEFT : H_IDLE;
                default: state_nxt = state_p2;
            endcase
        end
    end

    always_comb begin
        horiz = KEY_NONE;
        case (state_p2)
            H_LEFT:  horiz = BIND_L;
            H_RIGHT: horiz = BIND_R;
            default: horiz = KEY_NONE;
        endcase
    end

    assign keycode    = {(up_p2 ? BIND_U : KEY_NONE), horiz};
    assign jump_pulse = jump_p2;

endmodule

// File: rtl/keymap_arbiter.sv
// Maps HID key slots to per-player movement keycodes with rollover rejection and a sticky start flag.
// Build macro KEYMAP_DEBOUNCE_EN enables per-key debounce inside each keymap_player.
module keymap_arbiter
    import keymap_pkg::*;
#(
    parameter int                       NUM_SLOTS       = 4,
    parameter int                       NUM_PLAYERS     = 2,
    parameter logic [NUM_PLAYERS*8-1:0] BIND_LEFT       = {8'h5c, 8'h04},
    parameter logic [NUM_PLAYERS*8-1:0] BIND_RIGHT      = {8'h5e, 8'h07},
    parameter logic [NUM_PLAYERS*8-1:0] BIND_UP         = {8'h60, 8'h1a},
    parameter int                       DEBOUNCE_CYCLES = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [NUM_SLOTS*8-1:0]   keys_in,
    input  logic                     clear_start,
    output logic [NUM_PLAYERS*16-1:0] keycode_out,
    output logic [NUM_PLAYERS-1:0]   jump_pulse,
    output logic                     game_started
);

    logic reject;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("keymap_arbiter: DEBOUNCE_CYCLES must be at least 1");
    end

    // An ErrorRollOver code in any slot makes the whole sample untrustworthy.
    always_comb begin
        reject = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (keys_in[8*s +: 8] == KEY_ROLLOVER) reject = 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        keymap_player #(
            .NUM_SLOTS       (NUM_SLOTS),
            .BIND_L          (BIND_LEFT[8*p +: 8]),
            .BIND_R          (BIND_RIGHT[8*p +: 8]),
            .BIND_U          (BIND_UP[8*p +: 8]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_player (
            .Clk        (Clk),
            .Reset_n    (Reset_n),
            .keys_in    (keys_in),
            .reject     (reject),
            .keycode    (keycode_out[16*p +: 16]),
            .jump_pulse (jump_pulse[p])
        );
    end

    // Stage 3: sticky start flag follows the registered keycodes; clear has priority.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            game_started <= 1'b0;
        end else if (clear_start) begin
            game_started <= 1'b0;
        end else if (|keycode_out) begin
            game_started <= 1'b1;
        end
    end

endmodule

// File: tb/tb_keymap_arbiter.sv
// Randomised and directed bench for keymap_arbiter against a behavioural key-history model.
module tb_keymap_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] keys_in;
    logic        clear_start;
    logic [31:0] keycode_out;
    logic [1:0]  jump_pulse;
    logic        game_started;

    keymap_arbiter dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .keys_in      (keys_in),
        .clear_start  (clear_start),
        .keycode_out  (keycode_out),
        .jump_pulse   (jump_pulse),
        .game_started (game_started)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [7:0] BL   [2]  = '{8'h04, 8'h5c};
    localparam logic [7:0] BR   [2]  = '{8'h07, 8'h5e};
    localparam logic [7:0] BU   [2]  = '{8'h1a, 8'h60};
    localparam logic [7:0] POOL [10] = '{8'h00, 8'h00, 8'h04, 8'h07, 8'h1a,
                                         8'h5c, 8'h5e, 8'h60, 8'h22, 8'h04};

    int n_chk  = 0;
    int n_pass = 0;

    // Model: last two trusted key snapshots per player, the direction the player is moving
    // (-1 left, 0 none, +1 right) and what the outputs should show after each edge.
    logic [2:0]  m_now  [2];
    logic [2:0]  m_last [2];
    int          m_dir  [2];
    logic        m_up   [2];
    logic        m_jump [2];
    logic        m_gs;
    logic [31:0] m_kc;
    logic [1:0]  m_jp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Bit 2 = left, bit 1 = right, bit 0 = up.
    function automatic logic [2:0] pressed(input logic [31:0] k, input int p);
        logic [2:0] d;
        logic [7:0] b;
        d = 3'b000;
        for (int s = 0; s < 4; s++) begin
            b = k[8*s +: 8];
            if (b != 8'h00 && b == BL[p]) d[2] = 1'b1;
            if (b != 8'h00 && b == BR[p]) d[1] = 1'b1;
            if (b != 8'h00 && b == BU[p]) d[0] = 1'b1;
        end
        return d;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_now[p] = 3'b000; m_last[p] = 3'b000; m_dir[p] = 0;
            m_up[p] = 1'b0; m_jump[p] = 1'b0;
        end
        m_gs = 1'b0; m_kc = 32'h0; m_jp = 2'b00;
    endtask

    task automatic model_edge(input logic [31:0] k, input logic clr, input logic rn);
        logic rollover;
        logic l, r, u, new_l, new_r;
        if (!rn) begin
            model_reset();
            return;
        end
        if (clr) m_gs = 1'b0;
        else if (m_kc != 32'h0) m_gs = 1'b1;
        for (int p = 0; p < 2; p++) begin
            l = m_now[p][2]; r = m_now[p][1]; u = m_now[p][0];
            new_l = l && !m_last[p][2];
            new_r = r && !m_last[p][1];
            if (new_l && new_r) m_dir[p] = 0;
            else if (new_l) m_dir[p] = -1;
            else if (new_r) m_dir[p] = 1;
            else if (m_dir[p] == -1 && !l) m_dir[p] = r ? 1 : 0;
            else if (m_dir[p] == 1 && !r) m_dir[p] = l ? -1 : 0;
            m_up[p]   = u;
            m_jump[p] = u && !m_last[p][0];
        end
        rollover = 1'b0;
        for (int s = 0; s < 4; s++) if (k[8*s +: 8] == 8'h01) rollover = 1'b1;
        for (int p = 0; p < 2; p++) begin
            m_last[p] = m_now[p];
            if (!rollover) m_now[p] = pressed(k, p);
        end
        for (int p = 0; p < 2; p++) begin
            m_kc[16*p +: 8]     = (m_dir[p] < 0) ? BL[p] : (m_dir[p] > 0) ? BR[p] : 8'h00;
            m_kc[16*p + 8 +: 8] = m_up[p] ? BU[p] : 8'h00;
            m_jp[p]             = m_jump[p];
        end
    endtask

    task automatic cycle(input logic [31:0] k, input logic clr, input logic rn);
        keys_in = k; clear_start = clr; Reset_n = rn;
        @(posedge Clk);
        model_edge(k, clr, rn);
        @(negedge Clk);
        chk("keycode_out", keycode_out, m_kc);
        chk("jump_pulse", jump_pulse, m_jp);
        chk("game_started", game_started, m_gs);
    endtask

    task automatic run(input logic [31:0] k, input int n);
        for (int i = 0; i < n; i++) cycle(k, 1'b0, 1'b1);
    endtask

    int          cnt_j0, cnt_j1, cnt_up0;
    logic [31:0] rk, k;
    int          slot;

    initial begin
        Reset_n = 1'b0; keys_in = 32'h0; clear_start = 1'b0;
        model_reset();
        @(negedge Clk);

        // Reset with keys already held, then release.
        for (int i = 0; i < 3; i++) cycle(32'h0000_5c04, 1'b0, 1'b0);
        chk("rst_keycode", keycode_out, 32'h0);
        chk("rst_jump", jump_pulse, 2'b00);
        chk("rst_started", game_started, 1'b0);
        cycle(32'h0000_5c04, 1'b0, 1'b1);
        chk("rel_edge1_keycode", keycode_out, 32'h0);
        cycle(32'h0000_5c04, 1'b0, 1'b1);
        chk("rel_edge2_keycode", keycode_out, 32'h005c_0004);
        chk("rel_edge2_started", game_started, 1'b0);
        cycle(32'h0000_5c04, 1'b0, 1'b1);
        chk("rel_edge3_started", game_started, 1'b1);

        // Last-pressed-wins.
        run(32'h0, 3);
        run(32'h0000_0004, 3);
        chk("lpw_left", keycode_out[7:0], 8'h04);
        run(32'h0000_0704, 3);
        chk("lpw_right_newest", keycode_out[7:0], 8'h07);
        run(32'h0000_0004, 3);
        chk("lpw_back_left", keycode_out[7:0], 8'h04);
        run(32'h0, 3);
        chk("lpw_none", keycode_out[7:0], 8'h00);

        // Simultaneous press cancels; releasing one is not a new edge.
        run(32'h0704_0000, 4);
        chk("simul_both", keycode_out[7:0], 8'h00);
        run(32'h0004_0000, 3);
        chk("simul_release_r", keycode_out[7:0], 8'h00);
        run(32'h0, 3);

        // Jump: one pulse per press, up byte for the hold duration.
        cnt_j0 = 0; cnt_j1 = 0; cnt_up0 = 0;
        for (int i = 0; i < 12; i++) begin
            cycle((i < 10) ? 32'h0000_001a : 32'h0, 1'b0, 1'b1);
            cnt_j0 += int'(jump_pulse[0]);
            cnt_j1 += int'(jump_pulse[1]);
            cnt_up0 += (keycode_out[15:8] == 8'h1a) ? 1 : 0;
        end
        chk("jump0_pulses", cnt_j0, 1);
        chk("jump0_other", cnt_j1, 0);
        chk("up0_cycles", cnt_up0, 10);
        cnt_j0 = 0; cnt_j1 = 0;
        for (int i = 0; i < 8; i++) begin
            cycle((i < 5) ? 32'h0060_0000 : 32'h0, 1'b0, 1'b1);
            cnt_j0 += int'(jump_pulse[0]);
            cnt_j1 += int'(jump_pulse[1]);
        end
        chk("jump1_pulses", cnt_j1, 1);
        chk("jump1_other", cnt_j0, 0);

        // Rollover samples are ignored entirely.
        run(32'h0000_0004, 3);
        for (int i = 0; i < 3; i++) begin
            cycle(32'h0101_0101, 1'b0, 1'b1);
            chk("rollover_keycode", keycode_out, 32'h0000_0004);
            chk("rollover_jump", jump_pulse, 2'b00);
        end
        run(32'h0000_0004, 3);
        chk("post_rollover", keycode_out, 32'h0000_0004);

        // clear_start: wins over a simultaneous set, then re-sets while a key is active.
        cycle(32'h0000_0004, 1'b1, 1'b1);
        chk("clr_wins", game_started, 1'b0);
        cycle(32'h0000_0004, 1'b0, 1'b1);
        chk("clr_reset_again", game_started, 1'b1);
        run(32'h0, 3);
        cycle(32'h0, 1'b1, 1'b1);
        chk("clr_idle", game_started, 1'b0);
        run(32'h0, 4);
        chk("clr_stays", game_started, 1'b0);

        // Mid-operation reset with a key held.
        run(32'h0000_0700, 3);
        cycle(32'h0000_0700, 1'b0, 1'b0);
        chk("midrst_keycode", keycode_out, 32'h0);
        run(32'h0000_0700, 2);
        chk("midrst_repress", keycode_out[7:0], 8'h07);

        // Randomised traffic.
        rk = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            for (int s = 0; s < 4; s++)
                if ($urandom_range(0, 3) == 0) rk[8*s +: 8] = POOL[$urandom_range(0, 9)];
            k = rk;
            if ($urandom_range(0, 39) == 0) begin
                slot = int'($urandom_range(0, 3));
                k[8*slot +: 8] = 8'h01;
            end
            cycle(k, ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
